// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
//
// Drives the external function unit (ALU) as its only adder. It issues one
// ADD or PASS per cycle and takes 32 iterations per product.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a multiply (sampled only while idle)
//   mcand, mplier     operands, captured on an accepted start
//   alu_a, alu_b      function-unit operand drive (A = p_hi, B = multiplicand)
//   alu_gselect       function-unit op select {S2,S1,S0,Cin}
//   alu_g, alu_c      function-unit result and carry-out
//   busy              high while iterating
//   done              one-cycle pulse when product becomes valid
//   product           last result, held until the next one completes
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_gselect,
  input  logic [WIDTH-1:0]   alu_g,
  input  logic               alu_c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [3:0] GS_PASS = 4'b0000;  // G = A, C = 0
  localparam logic [3:0] GS_ADD  = 4'b0010;  // G = A + B, C = carry

  logic [0:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   p_hi_q,    p_hi_d;
  logic [WIDTH-1:0]   p_lo_q,    p_lo_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q,    done_d;
  logic [2*WIDTH-1:0] shifted;

  // The 2*WIDTH+1 bit value {C, G, p_lo} shifted right by one. The carry must
  // be kept: p_hi + mcand can exceed WIDTH bits.
  assign shifted = {alu_c, alu_g, p_lo_q[WIDTH-1:1]};

  // ALU drive depends on registered state only, never on the start/operand inputs.
  assign alu_a       = p_hi_q;
  assign alu_b       = mcand_q;
  assign alu_gselect = (state_q == S_RUN && p_lo_q[0]) ? GS_ADD : GS_PASS;

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = mcand;
          p_lo_d  = mplier;
          p_hi_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {p_hi_d, p_lo_d} = shifted;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d   = S_IDLE;
          product_d = shifted;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq. It models the function unit (ADD / PASS)
// behaviourally and runs a vector table plus sequences for the multi-cycle
// corner cases.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] mcand, mplier;
  logic [31:0] alu_a, alu_b, alu_g;
  logic [3:0]  alu_gselect;
  logic        alu_c;
  logic        busy, done;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gselect(alu_gselect),
    .alu_g(alu_g), .alu_c(alu_c), .busy(busy), .done(done), .product(product)
  );

  // Function-unit model: an unsupported select yields an all-ones result,
  // which corrupts the product.
  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_gselect)
      4'b0010: {alu_c, alu_g} = sum;
      4'b0000: {alu_c, alu_g} = {1'b0, alu_a};
      default: {alu_c, alu_g} = {1'b1, 32'hFFFF_FFFF};
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Counts cycles from the cycle after the accept edge until done is seen.
  // Also records which iterations issued ADD and how many cycles were busy.
  task automatic wait_done(output int n, output logic [31:0] add_mask,
                           output int busy_cnt, output int bad_sel);
    n = 1; add_mask = '0; busy_cnt = 0; bad_sel = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (alu_gselect == 4'b0010 && n <= 32) add_mask[n-1] = 1'b1;
      if (alu_gselect != 4'b0010 && alu_gselect != 4'b0000) bad_sel++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int n, bc, bs;
    logic [31:0] m;
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy after start"}, {63'd0, busy}, 64'd1);
    wait_done(n, m, bc, bs);
    chk({name, " latency"}, 64'(n), 64'd33);
    chk({name, " busy cycles"}, 64'(bc), 64'd32);
    chk({name, " add iterations"}, {32'd0, m}, {32'd0, b});
    chk({name, " illegal gselect"}, 64'(bs), 64'd0);
    chk({name, " product"}, product, exp);
    @(negedge clk);
    chk({name, " done pulse width"}, {63'd0, done}, 64'd0);
    chk({name, " product held"}, product, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, bc, bs, seen;
    logic [31:0] m;

    vecs[0] = '{"basic 3*5",     32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{"carry max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"zero mplier",   32'h1234_5678, 32'd0,          64'd0};
    vecs[3] = '{"zero mcand",    32'd0,          32'hDEAD_BEEF, 64'd0};
    vecs[4] = '{"max*1",         32'hFFFF_FFFF, 32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{"msb*msb",       32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{"2^16*2^16",     32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[7] = '{"max*2",         32'hFFFF_FFFF, 32'd2,          64'h0000_0001_FFFF_FFFE};

    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(negedge clk);
    chk("reset busy",    {63'd0, busy}, 64'd0);
    chk("reset done",    {63'd0, done}, 64'd0);
    chk("reset product", product, 64'd0);
    chk("reset alu_a",   {32'd0, alu_a}, 64'd0);
    chk("reset alu_b",   {32'd0, alu_b}, 64'd0);
    chk("reset gselect", {60'd0, alu_gselect}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p);

    // A start while busy is ignored: one product and one done only.
    @(negedge clk);
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; mcand = 32'd100; mplier = 32'd100;
    @(negedge clk);
    start = 1'b0;
    chk("busy-start still busy", {63'd0, busy}, 64'd1);
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        seen++;
        chk("busy-start product", product, 64'd63);
      end
      @(negedge clk);
    end
    chk("busy-start done count", 64'(seen), 64'd1);

    // Back-to-back: start held through done, new operands accepted in the done cycle.
    @(negedge clk);
    start = 1'b1; mcand = 32'd2; mplier = 32'd3;
    @(negedge clk);
    wait_done(n, m, bc, bs);
    chk("b2b first latency", 64'(n), 64'd33);
    chk("b2b first product", product, 64'd6);
    mcand = 32'h8000_0000; mplier = 32'd2;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no gap busy", {63'd0, busy}, 64'd1);
    chk("b2b product held", product, 64'd6);
    wait_done(n, m, bc, bs);
    chk("b2b second latency", 64'(n), 64'd33);
    chk("b2b second product", product, 64'h0000_0001_0000_0000);

    // Reset in the middle of a multiply aborts asynchronously with no done.
    @(negedge clk);
    start = 1'b1; mcand = 32'hDEAD_BEEF; mplier = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre-reset alu_a nonzero", {63'd0, (alu_a != 32'd0)}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid-reset busy",    {63'd0, busy}, 64'd0);
    chk("mid-reset product", product, 64'd0);
    chk("mid-reset alu_a",   {32'd0, alu_a}, 64'd0);
    chk("mid-reset alu_b",   {32'd0, alu_b}, 64'd0);
    chk("mid-reset gselect", {60'd0, alu_gselect}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    chk("after reset idle", 64'(seen), 64'd0);
    do_mul("post-reset 4*4", 32'd4, 32'd4, 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
